// File: rtl/univ_reg_n_if.sv
// Control/data bundle of the universal register: the master drives the
// operation and its data, the slave returns the register state.
interface univ_reg_n_if #(
  parameter int WIDTH = 4
);
  logic             en;
  logic             clr;
  logic [2:0]       mode;
  logic             sin_r;
  logic             sin_l;
  logic [WIDTH-1:0] I;
  logic [WIDTH-1:0] A;
  logic             sout;
  logic             co;

  modport master (output en, clr, mode, sin_r, sin_l, I, input A, sout, co);
  modport slave  (input en, clr, mode, sin_r, sin_l, I, output A, sout, co);
endinterface

// File: rtl/univ_reg_n.sv
// N-bit universal register: load, shift, rotate and up/down count in one
// registered datapath, with a registered serial-out bit and a count-wrap strobe.
module univ_reg_n #(
  parameter int              WIDTH     = 4,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic        clk,
  input  logic        rst,
  univ_reg_n_if.slave bus
);
  typedef enum logic [2:0] {
    M_HOLD = 3'b000,
    M_LOAD = 3'b001,
    M_SHR  = 3'b010,
    M_SHL  = 3'b011,
    M_ROR  = 3'b100,
    M_ROL  = 3'b101,
    M_UP   = 3'b110,
    M_DN   = 3'b111
  } mode_e;

  logic [WIDTH-1:0] a, a_nxt;
  logic             sout, sout_nxt;
  logic             co, co_nxt;
  mode_e            mode;

  assign mode = mode_e'(bus.mode);

  always_comb begin
    a_nxt    = a;
    sout_nxt = sout;
    co_nxt   = 1'b0;
    if (bus.clr) begin
      a_nxt    = '0;
      sout_nxt = 1'b0;
    end else if (bus.en) begin
      case (mode)
        M_HOLD: ;
        M_LOAD: a_nxt = bus.I;
        M_SHR: begin
          a_nxt    = {bus.sin_r, a[WIDTH-1:1]};
          sout_nxt = a[0];
        end
        M_SHL: begin
          a_nxt    = {a[WIDTH-2:0], bus.sin_l};
          sout_nxt = a[WIDTH-1];
        end
        M_ROR: begin
          a_nxt    = {a[0], a[WIDTH-1:1]};
          sout_nxt = a[0];
        end
        M_ROL: begin
          a_nxt    = {a[WIDTH-2:0], a[WIDTH-1]};
          sout_nxt = a[WIDTH-1];
        end
        // Wrap is detected on the pre-increment value so co lines up with
        // the edge that produces the wrapped A.
        M_UP: begin
          a_nxt  = a + 1'b1;
          co_nxt = &a;
        end
        M_DN: begin
          a_nxt  = a - 1'b1;
          co_nxt = ~|a;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a    <= RESET_VAL;
      sout <= 1'b0;
      co   <= 1'b0;
    end else begin
      a    <= a_nxt;
      sout <= sout_nxt;
      co   <= co_nxt;
    end
  end

  assign bus.A    = a;
  assign bus.sout = sout;
  assign bus.co   = co;
endmodule

// File: tb/tb_univ_reg_n.sv
// Directed bench for univ_reg_n: a 4-bit instance for the operation set and
// an 8-bit instance with a non-zero reset value for mid-cycle reset.
module tb_univ_reg_n;
  logic clk = 1'b0;
  logic rst4, rst8;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  univ_reg_n_if #(.WIDTH(4)) b4 ();
  univ_reg_n_if #(.WIDTH(8)) b8 ();

  univ_reg_n #(.WIDTH(4), .RESET_VAL(4'h0)) dut4 (.clk(clk), .rst(rst4), .bus(b4));
  univ_reg_n #(.WIDTH(8), .RESET_VAL(8'hA5)) dut8 (.clk(clk), .rst(rst8), .bus(b8));

  task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic op4(input logic en, input logic clr, input logic [2:0] mode,
                     input logic [3:0] i);
    b4.en = en; b4.clr = clr; b4.mode = mode; b4.I = i;
    step();
  endtask

  initial begin
    rst4 = 1'b1; rst8 = 1'b1;
    b4.en = 1'b1; b4.clr = 1'b0; b4.mode = 3'b001; b4.I = 4'b1010;
    b4.sin_r = 1'b0; b4.sin_l = 1'b0;
    b8.en = 1'b0; b8.clr = 1'b0; b8.mode = 3'b000; b8.I = 8'h00;
    b8.sin_r = 1'b0; b8.sin_l = 1'b0;
    #1;
    chk("rst_a", 8'(b4.A), 8'h0);
    chk("rst_sout", 8'(b4.sout), 8'h0);
    chk("rst_co", 8'(b4.co), 8'h0);
    step(); chk("rst_hold1", 8'(b4.A), 8'h0);
    step(); chk("rst_hold2", 8'(b4.A), 8'h0);
    rst4 = 1'b0;
    step(); chk("load_after_rst", 8'(b4.A), 8'hA);

    b4.sin_r = 1'b1;
    op4(1, 0, 3'b010, 4'h0); chk("shr1_a", 8'(b4.A), 8'hD); chk("shr1_sout", 8'(b4.sout), 8'h0);
    op4(1, 0, 3'b010, 4'h0); chk("shr2_a", 8'(b4.A), 8'hE); chk("shr2_sout", 8'(b4.sout), 8'h1);
    op4(1, 0, 3'b000, 4'h0); chk("hold_a", 8'(b4.A), 8'hE); chk("hold_sout", 8'(b4.sout), 8'h1);

    op4(1, 0, 3'b001, 4'hA); chk("load_a", 8'(b4.A), 8'hA);
    b4.sin_l = 1'b0;
    op4(1, 0, 3'b011, 4'h0); chk("shl_a", 8'(b4.A), 8'h4); chk("shl_sout", 8'(b4.sout), 8'h1);
    op4(1, 0, 3'b001, 4'h9); chk("load9", 8'(b4.A), 8'h9);
    op4(1, 0, 3'b100, 4'h0); chk("ror_a", 8'(b4.A), 8'hC); chk("ror_sout", 8'(b4.sout), 8'h1);
    op4(1, 0, 3'b101, 4'h0); chk("rol_a", 8'(b4.A), 8'h9); chk("rol_sout", 8'(b4.sout), 8'h1);
    // shift out a 0 so later checks can see sout holding through counts
    op4(1, 0, 3'b010, 4'h0); chk("shr3_sout", 8'(b4.sout), 8'h1);
    op4(1, 0, 3'b011, 4'h0); chk("shl2_a", 8'(b4.A), 8'h8); chk("shl2_sout", 8'(b4.sout), 8'h1);
    op4(1, 0, 3'b100, 4'h0); chk("ror2_sout", 8'(b4.sout), 8'h0);

    op4(1, 0, 3'b001, 4'hE); chk("load_e", 8'(b4.A), 8'hE);
    op4(1, 0, 3'b110, 4'h0); chk("up1_a", 8'(b4.A), 8'hF); chk("up1_co", 8'(b4.co), 8'h0);
    op4(1, 0, 3'b110, 4'h0); chk("up2_a", 8'(b4.A), 8'h0); chk("up2_co", 8'(b4.co), 8'h1);
    op4(1, 0, 3'b110, 4'h0); chk("up3_a", 8'(b4.A), 8'h1); chk("up3_co", 8'(b4.co), 8'h0);
    chk("count_sout_hold", 8'(b4.sout), 8'h0);
    op4(1, 0, 3'b001, 4'h0); chk("load0_co", 8'(b4.co), 8'h0);
    op4(1, 0, 3'b111, 4'h0); chk("dn_a", 8'(b4.A), 8'hF); chk("dn_co", 8'(b4.co), 8'h1);
    op4(1, 0, 3'b111, 4'h0); chk("dn2_a", 8'(b4.A), 8'hE); chk("dn2_co", 8'(b4.co), 8'h0);

    op4(1, 0, 3'b110, 4'h0); chk("up_f", 8'(b4.A), 8'hF);
    op4(0, 0, 3'b110, 4'h0); chk("en0_a", 8'(b4.A), 8'hF); chk("en0_co", 8'(b4.co), 8'h0);
    op4(1, 0, 3'b101, 4'h0); chk("rol_f_sout", 8'(b4.sout), 8'h1);
    op4(0, 1, 3'b110, 4'h0); chk("clr_a", 8'(b4.A), 8'h0); chk("clr_sout", 8'(b4.sout), 8'h0);
    op4(1, 0, 3'b001, 4'h6); chk("load6", 8'(b4.A), 8'h6);
    op4(1, 1, 3'b001, 4'hA); chk("clr_wins", 8'(b4.A), 8'h0);
    op4(1, 0, 3'b001, 4'hF); chk("loadf", 8'(b4.A), 8'hF);
    op4(1, 1, 3'b110, 4'h0); chk("clr_up_a", 8'(b4.A), 8'h0); chk("clr_up_co", 8'(b4.co), 8'h0);

    // 8-bit instance: reset value, then mid-cycle async reset while counting
    chk("rst8_a", 8'(b8.A), 8'hA5);
    rst8 = 1'b0;
    b8.en = 1'b1; b8.mode = 3'b001; b8.I = 8'h10;
    step(); chk("load8", 8'(b8.A), 8'h10);
    b8.mode = 3'b110;
    step(); chk("up8_1", 8'(b8.A), 8'h11);
    step(); chk("up8_2", 8'(b8.A), 8'h12);
    #4 rst8 = 1'b1;
    #1;
    chk("async_rst8_a", 8'(b8.A), 8'hA5);
    chk("async_rst8_co", 8'(b8.co), 8'h0);
    #2 rst8 = 1'b0;
    step(); chk("up8_after_rst", 8'(b8.A), 8'hA6); chk("up8_after_rst_co", 8'(b8.co), 8'h0);
    b8.mode = 3'b001; b8.I = 8'hFF;
    step();
    b8.mode = 3'b110;
    step(); chk("up8_wrap_a", 8'(b8.A), 8'h00); chk("up8_wrap_co", 8'(b8.co), 8'h1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
